mmio_block_copier: RTL and testbench

- Bus initiator for the memory-mapped IO space: drives the 15-bit address, write-enable and 16-bit write-data lines, and samples the 16-bit read-data line returned by the IO responder.
- Copies LEN consecutive words from a source address range to a destination address range, one read followed by one write per word.
- Main use: mirroring the button window (0..15) into the LED window (16..31) without CPU involvement. Sits beside the CPU on the IO bus; the two are muxed onto the bus by `busy`.

---
 rtl/luna_io_pkg.sv | 19 +
 rtl/mmio_block_copier.sv | 154 +++++++++++++++
 tb/tb_mmio_block_copier.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/luna_io_pkg.sv
// Shared IO-bus definitions: bus widths, IO map and the block-copier state type.
package luna_io_pkg;

  localparam int unsigned IO_ADDR_WIDTH = 15;
  localparam int unsigned IO_DATA_WIDTH = 16;
  localparam int unsigned IO_LEN_WIDTH  = 15;

  localparam int unsigned BUTTONS_BASE  = 0;
  localparam int unsigned LEDS_BASE     = 16;
  localparam int unsigned IO_WINDOW     = 16;

  typedef enum logic [1:0] {
    CP_IDLE   = 2'd0,
    CP_READ   = 2'd1,
    CP_WRITE  = 2'd2,
    CP_FINISH = 2'd3
  } copier_state_t;

endpackage

// File: rtl/mmio_block_copier.sv
// IO-bus initiator copying LEN words from a source range to a destination
// range, one read then one write per word. All outputs are registered.
module mmio_block_copier
  import luna_io_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = IO_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = IO_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH    = IO_LEN_WIDTH,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write_enable,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);

  copier_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [1:0]            wait_q, wait_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [LEN_WIDTH-1:0]  words_done_q, words_done_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_we_q, bus_we_d;
  logic [DATA_WIDTH-1:0] bus_data_out_q, bus_data_out_d;

  // Next-state, counters and registered-output values derived from the next state.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    len_d          = len_q;
    idx_d          = idx_q;
    wait_d         = wait_q;
    words_done_d   = words_done_q;
    bus_data_out_d = bus_data_out_q;
    aborted_d      = 1'b0;

    unique case (state_q)
      CP_IDLE: begin
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          len_d        = len;
          idx_d        = '0;
          wait_d       = '0;
          words_done_d = '0;
          state_d      = (len == '0) ? CP_FINISH : CP_READ;
        end
      end
      CP_READ: begin
        if (abort) begin
          state_d   = CP_IDLE;
          aborted_d = 1'b1;
        end else if (wait_q == 2'(READ_LATENCY)) begin
          // The write-data output register doubles as the read-data register,
          // so the captured word appears on the bus on entry to WRITE.
          bus_data_out_d = bus_data_in;
          wait_d         = '0;
          state_d        = CP_WRITE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      CP_WRITE: begin
        // The write is on the bus this cycle, so it counts even when aborted.
        idx_d        = idx_q + LEN_WIDTH'(1);
        words_done_d = words_done_q + LEN_WIDTH'(1);
        if (abort) begin
          state_d   = CP_IDLE;
          aborted_d = 1'b1;
        end else if (idx_q + LEN_WIDTH'(1) == len_q) begin
          state_d = CP_FINISH;
        end else begin
          state_d = CP_READ;
        end
      end
      CP_FINISH: begin
        state_d = CP_IDLE;
      end
      default: begin
        state_d = CP_IDLE;
      end
    endcase

    busy_d   = (state_d != CP_IDLE);
    done_d   = (state_d == CP_FINISH);
    bus_we_d = (state_d == CP_WRITE);

    bus_addr_d = bus_addr_q;
    if (state_d == CP_READ) begin
      bus_addr_d = src_d + ADDR_WIDTH'(idx_d);
    end else if (state_d == CP_WRITE) begin
      bus_addr_d = dst_d + ADDR_WIDTH'(idx_d);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CP_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      wait_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      words_done_q   <= '0;
      bus_addr_q     <= '0;
      bus_we_q       <= 1'b0;
      bus_data_out_q <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      words_done_q   <= words_done_d;
      bus_addr_q     <= bus_addr_d;
      bus_we_q       <= bus_we_d;
      bus_data_out_q <= bus_data_out_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign aborted          = aborted_q;
  assign words_done       = words_done_q;
  assign bus_addr         = bus_addr_q;
  assign bus_write_enable = bus_we_q;
  assign bus_data_out     = bus_data_out_q;

endmodule

// File: tb/tb_mmio_block_copier.sv
// Bench for mmio_block_copier: two instances (read latency 0 and 2), each with
// its own IO memory responder, checked every cycle against a transaction-level
// schedule built from the copy rules.
module tb_mmio_block_copier;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int LW = 15;

  typedef struct {
    int              d;
    int              cyc;
    bit              busy, done, abt, we, chka;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   dout;
    logic [LW-1:0]   wd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic          start [2];
  logic          abort [2];
  logic [AW-1:0] src [2];
  logic [AW-1:0] dst [2];
  logic [LW-1:0] len [2];
  logic          busy [2];
  logic          done [2];
  logic          aborted [2];
  logic          we [2];
  logic [LW-1:0] wd [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] dout [2];
  logic [DW-1:0] din [2];

  logic [DW-1:0] iomem  [2][32768];
  logic [DW-1:0] refmem [2][32768];
  logic [DW-1:0] ov [int];
  logic [AW-1:0] a1, a2, a3;

  exp_t q[$];
  int   we_log[$];
  int   cyc, run_c0, npass, nchk;
  bit   chk_en;
  logic [LW-1:0] idle_wd [2];
  logic [DW-1:0] idle_dout [2];
  int   done_cyc [2];
  int   abt_cyc [2];
  int   busy_cnt [2];
  int   we_cnt [2];

  always #5 clk = ~clk;

  assign din[0] = iomem[0][addr[0]];
  assign din[1] = iomem[1][a3];

  mmio_block_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
    .src_addr(src[0]), .dst_addr(dst[0]), .len(len[0]),
    .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .words_done(wd[0]),
    .bus_addr(addr[0]), .bus_write_enable(we[0]), .bus_data_out(dout[0]), .bus_data_in(din[0]));

  mmio_block_copier #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
    .src_addr(src[1]), .dst_addr(dst[1]), .len(len[1]),
    .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .words_done(wd[1]),
    .bus_addr(addr[1]), .bus_write_enable(we[1]), .bus_data_out(dout[1]), .bus_data_in(din[1]));

  function automatic int rl(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    else npass++;
  endtask

  function automatic void push(int d, int c, bit b, bit dn, bit ab, bit w, bit ca,
                               logic [AW-1:0] a, logic [DW-1:0] dv, logic [LW-1:0] n);
    exp_t e;
    e.d = d; e.cyc = c; e.busy = b; e.done = dn; e.abt = ab; e.we = w; e.chka = ca;
    e.addr = a; e.dout = dv; e.wd = n;
    q.push_back(e);
  endfunction

  // Expected cycle-by-cycle bus activity of one copy started in the current cycle.
  task automatic plan(int d, logic [AW-1:0] s, logic [AW-1:0] t, logic [LW-1:0] n, int ab);
    int c;
    logic [DW-1:0] dv, v;
    logic [AW-1:0] a;
    c  = cyc + 1;
    dv = idle_dout[d];
    ov.delete();
    if (n == 0) begin
      push(d, c, 1, 1, 0, 0, 0, '0, dv, '0);
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      a = s + AW'(k);
      for (int r = 0; r <= rl(d); r++) begin
        push(d, c, 1, 0, 0, 0, 1, a, dv, LW'(k));
        if (c == ab) begin push(d, c + 1, 0, 0, 1, 0, 0, '0, dv, LW'(k)); return; end
        c++;
      end
      v = ov.exists(int'(a)) ? ov[int'(a)] : refmem[d][a];
      a = t + AW'(k);
      dv = v;
      ov[int'(a)] = v;
      push(d, c, 1, 0, 0, 1, 1, a, dv, LW'(k));
      if (c == ab) begin push(d, c + 1, 0, 0, 1, 0, 0, '0, dv, LW'(k + 1)); return; end
      c++;
    end
    push(d, c, 1, 1, 0, 0, 0, '0, dv, n);
  endtask

  task automatic compare_one(int d);
    exp_t e;
    if (q.size() > 0 && q[0].d == d && q[0].cyc == cyc) begin
      e = q.pop_front();
      idle_wd[d]   = e.wd;
      idle_dout[d] = e.dout;
      if (e.we) refmem[d][e.addr] = e.dout;
    end else begin
      e.d = d; e.cyc = cyc; e.busy = 0; e.done = 0; e.abt = 0; e.we = 0; e.chka = 0;
      e.addr = '0; e.dout = idle_dout[d]; e.wd = idle_wd[d];
    end
    chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(e.busy));
    chk($sformatf("done%0d", d), 32'(done[d]), 32'(e.done));
    chk($sformatf("aborted%0d", d), 32'(aborted[d]), 32'(e.abt));
    chk($sformatf("we%0d", d), 32'(we[d]), 32'(e.we));
    chk($sformatf("words_done%0d", d), 32'(wd[d]), 32'(e.wd));
    chk($sformatf("data_out%0d", d), 32'(dout[d]), 32'(e.dout));
    if (e.chka) chk($sformatf("addr%0d", d), 32'(addr[d]), 32'(e.addr));
  endtask

  // One clock cycle: mid-cycle compare and responder write, then advance.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (chk_en) compare_one(d);
      if (done[d] === 1'b1) done_cyc[d] = cyc;
      if (aborted[d] === 1'b1) abt_cyc[d] = cyc;
      if (busy[d] === 1'b1) busy_cnt[d]++;
      if (we[d] === 1'b1) begin
        we_cnt[d]++;
        if (d == 1) we_log.push_back(cyc - run_c0);
        iomem[d][addr[d]] = dout[d];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    a3 = a2; a2 = a1; a1 = addr[1];
  endtask

  task automatic run(int d, logic [AW-1:0] s, logic [AW-1:0] t, logic [LW-1:0] n,
                     int ab_rel, int st2_rel, int rst_rel);
    bit fin;
    fin = 0;
    run_c0 = cyc;
    done_cyc[d] = -1; abt_cyc[d] = -1; busy_cnt[d] = 0; we_cnt[d] = 0;
    we_log.delete();
    src[d] = s; dst[d] = t; len[d] = n;
    plan(d, s, t, n, (ab_rel >= 0) ? run_c0 + ab_rel : -1);
    for (int i = 0; i < 3000; i++) begin
      start[d] = (i == 0) || (st2_rel >= 0 && cyc == run_c0 + st2_rel);
      if (i > 0 && start[d]) begin
        src[d] = AW'($urandom); dst[d] = AW'($urandom); len[d] = LW'($urandom_range(1, 9));
      end
      abort[d] = (ab_rel >= 0 && cyc == run_c0 + ab_rel);
      if (rst_rel >= 0 && cyc == run_c0 + rst_rel) begin
        reset = 1'b1;
        while (q.size() > 0 && q[q.size() - 1].cyc > cyc) void'(q.pop_back());
        push(0, cyc + 1, 0, 0, 0, 0, 0, '0, '0, '0);
        push(1, cyc + 1, 0, 0, 0, 0, 0, '0, '0, '0);
      end else begin
        reset = 1'b0;
      end
      step();
      if (q.size() == 0 && busy[d] === 1'b0 && reset == 1'b0) begin fin = 1; break; end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    start[d] = 0; abort[d] = 0; reset = 0;
  endtask

  function automatic logic [15:0] leds();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = iomem[0][16 + k][0];
    return r;
  endfunction

  initial begin
    logic [15:0] pat, snap, v;
    logic [DW-1:0] s0, s1, s2;
    logic [AW-1:0] rs, rt;
    int d, n, ab, st2;

    npass = 0; nchk = 0; cyc = 0; chk_en = 0;
    reset = 1'b1;
    a1 = '0; a2 = '0; a3 = '0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; abort[i] = 0; src[i] = '0; dst[i] = '0; len[i] = '0;
      idle_wd[i] = '0; idle_dout[i] = '0;
      done_cyc[i] = -1; abt_cyc[i] = -1; busy_cnt[i] = 0; we_cnt[i] = 0;
    end
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32768; a++) begin
        v = 16'($urandom);
        iomem[i][a] = v; refmem[i][a] = v;
      end
    pat = 16'hA5C3;
    for (int k = 0; k < 16; k++) begin
      iomem[0][k] = {15'd0, pat[k]}; refmem[0][k] = {15'd0, pat[k]};
    end

    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_aborted", 32'(aborted[i]), 0);
      chk("rst_we", 32'(we[i]), 0);
      chk("rst_words_done", 32'(wd[i]), 0);
      chk("rst_addr", 32'(addr[i]), 0);
      chk("rst_data_out", 32'(dout[i]), 0);
    end
    reset = 1'b0;
    chk_en = 1;
    step();

    // Abort during the read of word 3: three LED words written, rest untouched.
    snap = leds();
    run(0, 15'd0, 15'd16, 15'd16, 7, -1, -1);
    chk("abort_words_done", 32'(wd[0]), 3);
    chk("abort_pulse_cycle", 32'(abt_cyc[0] - run_c0), 8);
    chk("abort_no_done", 32'(done_cyc[0]), 32'hFFFF_FFFF);
    v = leds();
    chk("abort_leds_low", 32'(v[2:0]), 32'(pat[2:0]));
    chk("abort_leds_high", 32'(v[15:3]), 32'(snap[15:3]));

    // Buttons mirror.
    run(0, 15'd0, 15'd16, 15'd16, -1, -1, -1);
    chk("mirror_done_cycle", 32'(done_cyc[0] - run_c0), 33);
    chk("mirror_words_done", 32'(wd[0]), 16);
    chk("mirror_leds", 32'(leds()), 32'hA5C3);
    chk("mirror_writes", 32'(we_cnt[0]), 16);

    // Zero length.
    run(0, 15'd100, 15'd200, 15'd0, -1, -1, -1);
    chk("zero_done_cycle", 32'(done_cyc[0] - run_c0), 1);
    chk("zero_writes", 32'(we_cnt[0]), 0);
    chk("zero_busy_cycles", 32'(busy_cnt[0]), 1);

    // Address wrap at the top of the IO space.
    s0 = iomem[0][15'h7FFE]; s1 = iomem[0][15'h7FFF]; s2 = iomem[0][0];
    run(0, 15'h7FFE, 15'd16, 15'd3, -1, -1, -1);
    chk("wrap_w0", 32'(iomem[0][16]), 32'(s0));
    chk("wrap_w1", 32'(iomem[0][17]), 32'(s1));
    chk("wrap_w2", 32'(iomem[0][18]), 32'(s2));

    // Start and abort together in IDLE: start wins.
    run(0, 15'd40, 15'd60, 15'd2, 0, -1, -1);
    chk("start_abort_done", 32'(done_cyc[0] - run_c0), 5);
    // Abort during the write of word 1: that write counts.
    run(0, 15'd300, 15'd400, 15'd5, 4, -1, -1);
    chk("abort_write_wd", 32'(wd[0]), 2);
    // Abort in FINISH is ignored.
    run(0, 15'd500, 15'd600, 15'd2, 5, -1, -1);
    chk("abort_finish_done", 32'(done_cyc[0] - run_c0), 5);
    chk("abort_finish_none", 32'(abt_cyc[0]), 32'hFFFF_FFFF);

    // Read latency 2 with a colliding start at cycle 5.
    run(1, 15'd1000, 15'd2000, 15'd4, -1, 5, -1);
    chk("lat_writes", 32'(we_log.size()), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("lat_we%0d", k), 32'((k < we_log.size()) ? we_log[k] : -1), 32'(4 * (k + 1)));
    chk("lat_done_cycle", 32'(done_cyc[1] - run_c0), 17);

    // Reset in the middle of a copy, then a fresh copy.
    run(1, 15'd3000, 15'd4000, 15'd16, -1, -1, 10);
    chk("rstmid_busy", 32'(busy[1]), 0);
    chk("rstmid_words_done", 32'(wd[1]), 0);
    chk("rstmid_no_done", 32'(done_cyc[1]), 32'hFFFF_FFFF);
    run(1, 15'd3000, 15'd4000, 15'd5, -1, -1, -1);
    chk("rstmid_fresh_done", 32'(done_cyc[1] - run_c0), 21);
    chk("rstmid_fresh_wd", 32'(wd[1]), 5);

    // Randomised copies, including overlapping ranges, aborts and collisions.
    for (int t = 0; t < 16; t++) begin
      d  = t % 2;
      n  = $urandom_range(0, 12);
      rs = AW'($urandom);
      rt = ($urandom_range(0, 2) == 0) ? rs + AW'($urandom_range(1, 3)) : AW'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n * (rl(d) + 2) + 1) : -1;
      st2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : -1;
      run(d, rs, rt, LW'(n), ab, st2, -1);
      step();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
